fir_result_collector: RTL
=========================

// Module: fir_result_collector
// PURPOSE
//  AXI-Stream slave sitting directly downstream of the FIR core's sm_t* output port.
//  Buffers output samples Y[n] in a small FIFO and writes each sample, in order, into a result BRAM.
//  Checks tlast against the programmed length and keeps a running 32-bit checksum.
//  Reports busy/done/error status to the control plane for firmware readback.
// PARAMETERS
//  pADDR_WIDTH  12  BRAM byte-address width; word index = address[pADDR_WIDTH-1:2]
//  pDATA_WIDTH  32  sample width
//  FIFO_DEPTH    4  skid FIFO entries (power of 2, >=2)
// PORTS
//  axis_clk      in   1            clock
//  axis_rst_n    in   1            reset, asynchronous, active-low
//  start         in   1            1-cycle pulse: arm a new collection (honoured in IDLE/DONE only)
//  exp_len       in   32           expected sample count, sampled on accepted start
//  s_tvalid      in   1            AXIS slave valid (from FIR sm_tvalid)
//  s_tdata       in   pDATA_WIDTH  AXIS slave data (from FIR sm_tdata)
//  s_tlast       in   1            AXIS slave last (from FIR sm_tlast)
//  s_tready      out  1            AXIS slave ready (to FIR sm_tready)
//  res_WE        out  4            result BRAM byte write enables
//  res_EN        out  1            result BRAM enable
//  res_Di        out  pDATA_WIDTH  result BRAM write data
//  res_A         out  pADDR_WIDTH  result BRAM byte address
//  busy          out  1            state is RUN or DRAIN
//  done          out  1            state is DONE
//  count         out  32           samples written to BRAM in the current run
//  checksum      out  32           modulo-2^32 sum of all samples written in the current run
//  err_early     out  1            tlast arrived before beat exp_len
//  err_nolast    out  1            beat exp_len arrived without tlast
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0, including res_WE, res_EN, s_tready, count, checksum and both error flags. FIFO is emptied.
//  FSM: IDLE -start-> RUN; RUN -terminating beat accepted-> DRAIN; DRAIN -FIFO empty-> DONE; DONE -start-> RUN.
//   Terminating beat: tlast, or the beat with index exp_len-1.
//   On start: latch exp_len; clear beat index, wr_idx, count, checksum, err_early and err_nolast.
//   start while RUN or DRAIN is ignored.
//   exp_len==0: start -> DONE on the next cycle; no beats are accepted; count stays 0.
//  Handshake:
//   s_tready = (state==RUN) & !fifo_full, where fifo_full is a registered flag.
//   A beat is accepted when s_tvalid & s_tready; {s_tlast,s_tdata} is pushed on that edge.
//   s_tready does not depend on s_tvalid.
//   No push in a cycle where FIFO is full, even if a pop occurs in the same cycle.
//  Length check, on each accepted beat with index i (0-based):
//   tlast & i<exp_len-1   -> err_early=1, go to DRAIN.
//   !tlast & i==exp_len-1 -> err_nolast=1, go to DRAIN.
//   tlast & i==exp_len-1  -> clean end, go to DRAIN.
//  Drain to BRAM:
//   Whenever the FIFO is non-empty, pop one entry per cycle.
//   In the pop cycle: res_EN=1, res_WE=4'hF, res_Di=entry data, res_A=wr_idx<<2.
//   Also on the pop: wr_idx+=1, count+=1, checksum+=data.
//   res_EN=0 and res_WE=0 in all other cycles.
//  Latency: beat accepted at edge N is written to BRAM in cycle N+1 at the earliest (FIFO was empty).
//   done rises the cycle after the final pop.
//  Wrap: wr_idx is (pADDR_WIDTH-2) bits and wraps silently to 0. count and checksum wrap modulo 2^32.
//  Sticky: error flags, count and checksum hold their values through DONE until the next accepted start.
//  Simultaneous push+pop with the FIFO non-full: occupancy is unchanged.
//  Reset mid-run: immediate return to the reset values above; no further BRAM write.
// STRUCTURE
//  Shared package fir_pkg:
//   state encodings IDLE/RUN/DRAIN/DONE;
//   WORD_SHIFT=2 (byte address = word index << 2);
//   BRAM_WE_ALL=4'hF.
//  One sub-module: fir_sync_fifo
//   WIDTH=pDATA_WIDTH+1, DEPTH=FIFO_DEPTH; registered full/empty flags; async active-low reset.
//  FSM, length checker and BRAM write port are in this module.
// TESTING
//  1. exp_len=3; beats 5,6,7 with tlast on 7; s_tvalid held high
//     -> BRAM words 0..2 = 5,6,7; count=3; checksum=18; done=1; no errors.
//  2. exp_len=4; tlast on beat 2
//     -> err_early=1; count=2; state DONE; the 3rd beat is not accepted.
//  3. exp_len=2; no tlast on beat 2 -> err_nolast=1; count=2; s_tready=0 after beat 2.
//  4. FIFO_DEPTH=4; hold a pop-side stall by forcing the FIFO full with a stub
//     -> s_tready=0 while full; no beats lost; BRAM order preserved.
//  5. exp_len=0; start -> done=1 one cycle later; s_tready never asserted; no res_WE.
//  6. exp_len=2^(pADDR_WIDTH-2)+1 -> last word lands at res_A=0; count matches;
//     then assert reset mid-run -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fir_pkg
//  Purpose  : Shared encodings and constants for the FIR result collector.
//  Revision : 1.0  initial release
// ============================================================================
package fir_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam int         WORD_SHIFT  = 2;
    localparam logic [3:0] BRAM_WE_ALL = 4'hF;

endpackage
`default_nettype wire

// File: rtl/fir_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : fir_sync_fifo
//  Purpose  : Small first-word-fall-through FIFO with registered full/empty.
//  Revision : 1.0  initial release
// ============================================================================
module fir_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                     axis_clk,
    input  logic                     axis_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int                AW      = $clog2(DEPTH);
    localparam logic [AW:0]       c_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0]       c_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0]     c_PONE  = AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_level;
    logic             r_full;
    logic             r_empty;
    logic             w_push;
    logic             w_pop;
    logic [AW:0]      w_level_nxt;

    // A push is refused while full even if a pop frees a slot this cycle.
    assign w_push = i_push && !r_full;
    assign w_pop  = i_pop && !r_empty;

    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + c_ONE;
            2'b01:   w_level_nxt = r_level - c_ONE;
            default: w_level_nxt = r_level;
        endcase
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_push) r_wptr <= r_wptr + c_PONE;
            if (w_pop)  r_rptr <= r_rptr + c_PONE;
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == c_DEPTH);
            r_empty <= (w_level_nxt == '0);
        end
    end

    always_ff @(posedge axis_clk) begin
        if (w_push) r_mem[r_wptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/fir_result_collector.sv
`default_nettype none
// ============================================================================
//  Module   : fir_result_collector
//  Purpose  : AXIS sink that buffers FIR output samples and writes them to a
//             result BRAM, with length checking, checksum and status flags.
//  Revision : 1.0  initial release
// ============================================================================
module fir_result_collector
    import fir_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   start,
    input  logic [31:0]            exp_len,
    input  logic                   s_tvalid,
    input  logic [pDATA_WIDTH-1:0] s_tdata,
    input  logic                   s_tlast,
    output logic                   s_tready,
    output logic [3:0]             res_WE,
    output logic                   res_EN,
    output logic [pDATA_WIDTH-1:0] res_Di,
    output logic [pADDR_WIDTH-1:0] res_A,
    output logic                   busy,
    output logic                   done,
    output logic [31:0]            count,
    output logic [31:0]            checksum,
    output logic                   err_early,
    output logic                   err_nolast
);
    localparam int               LVL_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int               IDX_W     = pADDR_WIDTH - WORD_SHIFT;
    localparam logic [LVL_W-1:0] c_LVL_ONE = LVL_W'(1);
    localparam logic [IDX_W-1:0] c_IDX_ONE = IDX_W'(1);

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [31:0]            r_exp_len;
    logic [31:0]            r_beat_idx;
    logic [IDX_W-1:0]       r_wr_idx;
    logic [31:0]            r_count;
    logic [31:0]            r_checksum;
    logic                   r_err_early;
    logic                   r_err_nolast;

    logic                   w_tready;
    logic                   w_start_ok;
    logic                   w_accept;
    logic                   w_last_idx;
    logic                   w_term;
    logic                   w_pop;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [LVL_W-1:0]       w_fifo_level;
    logic [pDATA_WIDTH:0]   w_fifo_rdata;
    logic [pDATA_WIDTH-1:0] w_pop_data;

    assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_accept   = s_tvalid && w_tready;
    assign w_last_idx = (r_beat_idx == (r_exp_len - 32'd1));
    assign w_term     = w_accept && (s_tlast || w_last_idx);
    assign w_pop      = !w_fifo_empty;
    assign w_pop_data = w_fifo_rdata[pDATA_WIDTH-1:0];

    fir_sync_fifo #(
        .WIDTH (pDATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .axis_clk   (axis_clk),
        .axis_rst_n (axis_rst_n),
        .i_push     (w_accept),
        .i_wdata    ({s_tlast, s_tdata}),
        .i_pop      (w_pop),
        .o_rdata    (w_fifo_rdata),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty),
        .o_level    (w_fifo_level)
    );

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) r_state <= IDLE;
        else             r_state <= w_state_nxt;
    end

    // DRAIN never pushes, so a single remaining entry is the final pop.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DONE: if (start) w_state_nxt = (exp_len == 32'd0) ? DONE : RUN;
            RUN:        if (w_term) w_state_nxt = DRAIN;
            DRAIN:      if (w_fifo_empty || (w_fifo_level == c_LVL_ONE)) w_state_nxt = DONE;
            default:    w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_tready = (r_state == RUN) && !w_fifo_full;
        busy     = (r_state == RUN) || (r_state == DRAIN);
        done     = (r_state == DONE);
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_exp_len    <= '0;
            r_beat_idx   <= '0;
            r_err_early  <= 1'b0;
            r_err_nolast <= 1'b0;
        end else if (w_start_ok) begin
            r_exp_len    <= exp_len;
            r_beat_idx   <= '0;
            r_err_early  <= 1'b0;
            r_err_nolast <= 1'b0;
        end else if (w_accept) begin
            r_beat_idx <= r_beat_idx + 32'd1;
            if (s_tlast && !w_last_idx) r_err_early  <= 1'b1;
            if (!s_tlast && w_last_idx) r_err_nolast <= 1'b1;
        end
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_wr_idx   <= '0;
            r_count    <= '0;
            r_checksum <= '0;
        end else if (w_start_ok) begin
            r_wr_idx   <= '0;
            r_count    <= '0;
            r_checksum <= '0;
        end else if (w_pop) begin
            r_wr_idx   <= r_wr_idx + c_IDX_ONE;
            r_count    <= r_count + 32'd1;
            r_checksum <= r_checksum + 32'(w_pop_data);
        end
    end

    always_comb begin
        res_EN = w_pop;
        res_WE = w_pop ? BRAM_WE_ALL : 4'h0;
        res_Di = w_pop ? w_pop_data : '0;
        res_A  = w_pop ? (pADDR_WIDTH'(r_wr_idx) << WORD_SHIFT) : '0;
    end

    assign s_tready   = w_tready;
    assign count      = r_count;
    assign checksum   = r_checksum;
    assign err_early  = r_err_early;
    assign err_nolast = r_err_nolast;

endmodule
`default_nettype wire
